// File: rtl/fiber_dram_ctrl.sv
// Bank-to-DRAM bridge: one line writeback or fill at a time, writeback wins ties; fill data returns one cycle after the response.
// Backpressure: requests hold stable until i_mem_req_ready; returned fill holds until i_fill_ready; o_wb_ready only in IDLE.
module fiber_dram_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_dram_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_wb_valid,
    output logic                  o_wb_ready,
    input  logic                  i_fill_ready,
    output logic [DATA_WIDTH-1:0] o_fill_data,
    output logic                  o_fill_valid,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_we,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
    input  logic                  i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_resp_data,
    output logic [CNT_WIDTH-1:0]  o_wb_count,
    output logic [CNT_WIDTH-1:0]  o_fill_count,
    output logic                  o_err_spurious
);

    localparam int ALIGN_BITS = $clog2(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WB_ISSUE  = 3'd1,
        S_RD_ISSUE  = 3'd2,
        S_RD_WAIT   = 3'd3,
        S_RD_RETURN = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [CNT_WIDTH-1:0]  r_wb_cnt;
    logic [CNT_WIDTH-1:0]  r_fill_cnt;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_aligned_addr;
    logic                  w_resp_unexpected;

    assign w_aligned_addr    = i_dram_addr & ALIGN_MASK;
    // Only RD_WAIT consumes a response; anything else is a protocol error from memory.
    assign w_resp_unexpected = i_mem_resp_valid && (r_state != S_RD_WAIT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_fill     <= '0;
            r_wb_cnt   <= '0;
            r_fill_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_resp_unexpected) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_wb_valid) begin
                        r_addr  <= w_aligned_addr;
                        r_wdata <= i_wb_data;
                        r_state <= S_WB_ISSUE;
                    end else if (i_fill_ready) begin
                        r_addr  <= w_aligned_addr;
                        r_state <= S_RD_ISSUE;
                    end
                end
                S_WB_ISSUE: begin
                    if (i_mem_req_ready) begin
                        r_wb_cnt <= r_wb_cnt + CNT_WIDTH'(1);
                        r_state  <= S_IDLE;
                    end
                end
                S_RD_ISSUE: begin
                    if (i_mem_req_ready) begin
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (i_mem_resp_valid) begin
                        r_fill  <= i_mem_resp_data;
                        r_state <= S_RD_RETURN;
                    end
                end
                S_RD_RETURN: begin
                    // Returning to IDLE forces a fresh cycle before the next fill is taken.
                    if (i_fill_ready) begin
                        r_fill_cnt <= r_fill_cnt + CNT_WIDTH'(1);
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wb_ready      = (r_state == S_IDLE);
    assign o_mem_req_valid = (r_state == S_WB_ISSUE) || (r_state == S_RD_ISSUE);
    assign o_mem_req_we    = (r_state == S_WB_ISSUE);
    assign o_mem_req_addr  = r_addr;
    assign o_mem_req_wdata = r_wdata;
    assign o_fill_valid    = (r_state == S_RD_RETURN);
    assign o_fill_data     = r_fill;
    assign o_wb_count      = r_wb_cnt;
    assign o_fill_count    = r_fill_cnt;
    assign o_err_spurious  = r_err;

endmodule

// File: tb/tb_fiber_dram_ctrl.sv
// Directed bench for fiber_dram_ctrl: a transaction-level model (request/fill queues,
// outstanding flag, counts) is compared against the DUT every falling edge.
module tb_fiber_dram_ctrl;

    localparam int DW = 16;
    localparam int AW = 64;
    localparam int CW = 16;
    localparam int AB = $clog2(DW);

    logic          clk;
    logic          rst;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] wb_data;
    logic          wb_valid;
    logic          wb_ready;
    logic          fill_ready;
    logic [DW-1:0] fill_data;
    logic          fill_valid;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [CW-1:0] wb_count;
    logic [CW-1:0] fill_count;
    logic          err_spurious;

    fiber_dram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_dram_addr     (dram_addr),
        .i_wb_data       (wb_data),
        .i_wb_valid      (wb_valid),
        .o_wb_ready      (wb_ready),
        .i_fill_ready    (fill_ready),
        .o_fill_data     (fill_data),
        .o_fill_valid    (fill_valid),
        .o_mem_req_valid (req_valid),
        .i_mem_req_ready (req_ready),
        .o_mem_req_we    (req_we),
        .o_mem_req_addr  (req_addr),
        .o_mem_req_wdata (req_wdata),
        .i_mem_resp_valid(resp_valid),
        .i_mem_resp_data (resp_data),
        .o_wb_count      (wb_count),
        .o_fill_count    (fill_count),
        .o_err_spurious  (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t          exp_req[$];
    logic [DW-1:0] exp_fill[$];
    bit            hist_we[$];
    bit            m_issue;
    bit            m_out;
    bit            m_err;
    bit            m_idle;
    logic [CW-1:0] m_wb;
    logic [CW-1:0] m_fill;
    req_t          r_tmp;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return (a >> AB) << AB;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_req.delete();
            exp_fill.delete();
            m_issue = 0;
            m_out   = 0;
            m_err   = 0;
            m_wb    = '0;
            m_fill  = '0;
        end else begin
            m_idle = !m_issue && !m_out && (exp_fill.size() == 0);
            check("m_wb_ready", wb_ready, m_idle);
            check("m_req_valid", req_valid, m_issue);
            if (m_issue && exp_req.size() != 0) begin
                check("m_req_we", req_we, exp_req[0].we);
                check("m_req_addr", req_addr, exp_req[0].addr);
                if (exp_req[0].we) check("m_req_wdata", req_wdata, exp_req[0].data);
            end
            check("m_fill_valid", fill_valid, exp_fill.size() != 0);
            if (exp_fill.size() != 0) check("m_fill_data", fill_data, exp_fill[0]);
            check("m_wb_count", wb_count, m_wb);
            check("m_fill_count", fill_count, m_fill);
            check("m_err", err_spurious, m_err);

            // Advance the model with what happens at the next rising edge
            if (exp_fill.size() != 0 && fill_ready) begin
                void'(exp_fill.pop_front());
                m_fill = m_fill + 1'b1;
            end
            if (resp_valid) begin
                if (m_out) begin
                    exp_fill.push_back(resp_data);
                    m_out = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (m_issue) begin
                if (req_ready && exp_req.size() != 0) begin
                    r_tmp = exp_req.pop_front();
                    hist_we.push_back(r_tmp.we);
                    if (r_tmp.we) m_wb = m_wb + 1'b1;
                    else          m_out = 1;
                    m_issue = 0;
                end
            end else if (m_idle && (wb_valid || fill_ready)) begin
                r_tmp.we   = wb_valid;
                r_tmp.addr = align(dram_addr);
                r_tmp.data = wb_data;
                exp_req.push_back(r_tmp);
                m_issue = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0; dram_addr = '0; wb_data = '0; wb_valid = 0; fill_ready = 0;
        req_ready = 0; resp_valid = 0; resp_data = '0;
        #2 rst = 1;
        #2;
        check("rst_wb_ready", wb_ready, 1);
        check("rst_req_valid", req_valid, 0);
        check("rst_fill_valid", fill_valid, 0);
        check("rst_counts", {wb_count, fill_count}, 0);
        check("rst_err", err_spurious, 0);
        tick(); tick();
        rst = 0;

        // Single writeback, line-aligned address
        wb_valid = 1; dram_addr = 64'h1234; wb_data = 16'hBEEF; req_ready = 1;
        tick();
        wb_valid = 0;
        check("wb_req_valid", req_valid, 1);
        check("wb_req_we", req_we, 1);
        check("wb_req_addr", req_addr, 64'h1230);
        check("wb_req_wdata", req_wdata, 16'hBEEF);
        tick();
        check("wb_back_idle", wb_ready, 1);
        check("wb_count_1", wb_count, 1);

        // Fill with response three cycles after the request is seen, then bank stalls 4 cycles
        fill_ready = 1; dram_addr = 64'h40;
        tick();
        fill_ready = 0;
        check("rd_req_we", req_we, 0);
        check("rd_req_addr", req_addr, 64'h40);
        tick();
        check("rd_wait_busy", wb_ready, 0);
        tick();
        resp_valid = 1; resp_data = 16'hA5A5;
        tick();
        resp_valid = 0; resp_data = 16'h0000;
        check("fill_valid", fill_valid, 1);
        check("fill_data", fill_data, 16'hA5A5);
        repeat (4) begin
            tick();
            check("fill_stall_valid", fill_valid, 1);
            check("fill_stall_data", fill_data, 16'hA5A5);
        end
        fill_ready = 1;
        tick();
        fill_ready = 0;
        check("fill_count_1", fill_count, 1);
        check("fill_done", fill_valid, 0);

        // Simultaneous writeback and fill: write goes first
        hist_we.delete();
        wb_valid = 1; fill_ready = 1; dram_addr = 64'h2008; wb_data = 16'h1111;
        tick();
        wb_valid = 0;
        check("both_first_we", req_we, 1);
        tick();
        dram_addr = 64'h3000;
        tick();
        fill_ready = 0;
        check("both_second_we", req_we, 0);
        check("both_second_addr", req_addr, 64'h3000);
        tick(); tick();
        resp_valid = 1; resp_data = 16'h5A5A;
        tick();
        resp_valid = 0;
        fill_ready = 1;
        tick();
        fill_ready = 0;
        check("order_len", hist_we.size(), 2);
        if (hist_we.size() == 2) begin
            check("order_0", hist_we[0], 1);
            check("order_1", hist_we[1], 0);
        end
        check("both_wb_count", wb_count, 2);
        check("both_fill_count", fill_count, 2);

        // Memory backpressure on a writeback; bank inputs change meanwhile
        req_ready = 0; wb_valid = 1; dram_addr = 64'h5557; wb_data = 16'hCAFE;
        tick();
        wb_valid = 0; dram_addr = 64'h9990; wb_data = 16'hDEAD;
        repeat (5) begin
            tick();
            check("bp_valid", req_valid, 1);
            check("bp_addr", req_addr, 64'h5550);
            check("bp_wdata", req_wdata, 16'hCAFE);
        end
        check("bp_no_write_yet", wb_count, 2);
        req_ready = 1;
        tick();
        check("bp_single_write", wb_count, 3);
        tick();
        check("bp_still_3", wb_count, 3);

        // Spurious response while idle
        resp_valid = 1; resp_data = 16'h9999;
        tick();
        resp_valid = 0;
        check("spur_err", err_spurious, 1);
        check("spur_idle", wb_ready, 1);
        tick();
        check("spur_sticky", err_spurious, 1);

        // Reset while waiting for a read response, then the stale response arrives
        fill_ready = 1; dram_addr = 64'h80;
        tick();
        fill_ready = 0;
        tick();
        #2 rst = 1;
        #1;
        check("mid_rst_wb_ready", wb_ready, 1);
        check("mid_rst_req_valid", req_valid, 0);
        check("mid_rst_fill_valid", fill_valid, 0);
        check("mid_rst_counts", {wb_count, fill_count}, 0);
        check("mid_rst_err", err_spurious, 0);
        check("mid_rst_addr", req_addr, 0);
        check("mid_rst_fill_data", fill_data, 0);
        tick();
        rst = 0;
        resp_valid = 1; resp_data = 16'h7777;
        tick();
        resp_valid = 0;
        check("late_resp_err", err_spurious, 1);
        check("late_resp_no_fill", fill_valid, 0);

        // Writeback at the top of the address space
        wb_valid = 1; dram_addr = 64'hFFFF_FFFF_FFFF_FFFF; wb_data = 16'hFFFF;
        tick();
        wb_valid = 0;
        check("top_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFF0);
        tick();
        check("top_wb_count", wb_count, 1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
